// File: rtl/uart_pkg.sv
// Shared UART types: receiver and imem-loader state encodings plus frame constants.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH
    } ld_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver; rx_valid pulses one cycle after the stop-bit sample.
// No backpressure: a byte not consumed in its rx_valid cycle is lost.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rxd,
    output logic                      rx_valid,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      frame_err
);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    rx_state_t                 state, next;
    logic                      sync1, sync2, prev;
    logic [CNT_W-1:0]          cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      start_tick, bit_tick, stop_tick;

    always_ff @(posedge clk) begin
        if (reset) state <= RX_IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            RX_IDLE:  if (!sync2 && prev) next = RX_START;
            RX_START: if (start_tick) next = sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_idx == LAST_BIT) next = RX_STOP;
            RX_STOP:  if (stop_tick) next = RX_IDLE;
            default:  next = RX_IDLE;
        endcase
    end

    always_comb begin
        start_tick = (state == RX_START) && (cnt == HALF_LAST);
        bit_tick   = (state == RX_DATA)  && (cnt == FULL_LAST);
        stop_tick  = (state == RX_STOP)  && (cnt == FULL_LAST);
    end

    // Synchronizer idles high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            prev      <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= rxd;
            sync2     <= sync1;
            prev      <= sync2;
            rx_valid  <= stop_tick && sync2;
            frame_err <= stop_tick && !sync2;
            if (state == RX_IDLE || start_tick || bit_tick || stop_tick) cnt <= '0;
            else                                                          cnt <= cnt + CNT_W'(1);
            if (start_tick) bit_idx <= '0;
            if (bit_tick) begin
                shreg   <= {sync2, shreg[UART_DATA_BITS-1:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/imem_uart_loader.sv
// UART-to-imem loader: packs LE bytes into words; write lands one cycle after the 4th byte.
// No backpressure: imem accepts every strobe; the CPU is held while loading.
module imem_uart_loader
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 868,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_imem,
    input  logic                  uart_rxd,
    output logic                  imem_wr,
    output logic [ADDR_WIDTH-3:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  rx_err,
    output logic                  overflow
);
    localparam int WA_W = ADDR_WIDTH - 2;

    logic                      rx_valid, frame_err;
    logic [UART_DATA_BITS-1:0] rx_byte;
    ld_state_t                 state, next;
    logic                      load_q, start, accept, word_done;
    logic [1:0]                byte_cnt, cnt_upd;
    logic [23:0]               lanes;      // lanes 0..2; lane 3 completes the word directly
    logic                      wr_q;
    logic [WA_W-1:0]           word_addr, waddr_q;
    logic [31:0]               wdata_q;

    uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rxd       (uart_rxd),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
    );

    assign start     = (state == IDLE) && load_imem && !load_q;
    assign accept    = (state == LOAD) && rx_valid;
    assign cnt_upd   = accept ? byte_cnt + 2'd1 : byte_cnt;
    assign word_done = accept && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // The flush decision sees the byte accepted in the same cycle load_imem drops.
    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (start) next = LOAD;
            LOAD:    if (!load_imem) next = (cnt_upd != 2'd0) ? FLUSH : IDLE;
            FLUSH:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        imem_wr    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        if (state == FLUSH) begin
            imem_wr    = 1'b1;
            imem_addr  = word_addr;
            imem_wdata = {8'h00, lanes};
        end else if (wr_q) begin
            imem_wr    = 1'b1;
            imem_addr  = waddr_q;
            imem_wdata = wdata_q;
        end
        busy     = (state != IDLE);
        cpu_hold = load_imem || busy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_q    <= 1'b0;
            wr_q      <= 1'b0;
            byte_cnt  <= '0;
            lanes     <= '0;
            word_addr <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            rx_err    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            load_q <= load_imem;
            wr_q   <= word_done;
            rx_err <= start ? 1'b0 : (rx_err || frame_err);
            if (start) begin
                byte_cnt  <= '0;
                lanes     <= '0;
                word_addr <= '0;
                overflow  <= 1'b0;
            end else if (accept) begin
                byte_cnt <= cnt_upd;
                if (word_done) begin
                    wdata_q   <= {rx_byte, lanes};
                    waddr_q   <= word_addr;
                    word_addr <= word_addr + WA_W'(1);
                    lanes     <= '0;
                    if (&word_addr) overflow <= 1'b1;
                end else begin
                    lanes[{byte_cnt, 3'b000} +: 8] <= rx_byte;
                end
            end
        end
    end

endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Hardware instruction-memory loader for the SoC: while `load_imem` is high it receives a byte stream on the UART RX pin, assembles little-endian 32-bit words, and writes them into instruction RAM from word 0 upward. It is the in-silicon writer for the imem symbol arrays that simulation preloads through backdoor file loading. It sits between the board UART pin and the imem write port and holds the CPU in reset while loading.

## Interface
- `BAUD_DIV`, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `ADDR_WIDTH`, 16, imem byte-address width; word address is `ADDR_WIDTH-2` bits.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `load_imem` in 1: level; high = loading enabled.
- `uart_rxd` in 1: asynchronous serial input, 8N1, idle high.
- `imem_wr` out 1: one-cycle write strobe.
- `imem_addr` out ADDR_WIDTH-2: word address.
- `imem_wdata` out 32: word data; byte 0 in bits [7:0].
- `cpu_hold` out 1: high while `load_imem` is high or the loader is not IDLE.
- `busy` out 1: loader state ≠ IDLE.
- `rx_err` out 1: sticky framing error.
- `overflow` out 1: sticky address wrap.

## Operation
- RX path: 2-flop synchronizer on `uart_rxd`; both flops reset to 1.
- Receiver states:
  - RX_IDLE waits for a synchronized falling edge.
  - RX_START counts `BAUD_DIV/2` and re-samples. If high, the edge was a glitch: return to RX_IDLE.
  - RX_DATA samples 8 bits LSB-first, one every `BAUD_DIV` cycles.
  - RX_STOP samples once more. If 1, pulse `rx_valid` with `rx_byte`; if 0, drop the byte and set `rx_err`.
  - In both cases return to RX_IDLE.
- The receiver runs regardless of `load_imem`. Bytes received while the loader is not LOAD are discarded.
- Loader states:
  - IDLE → LOAD on rising edge of `load_imem`. Clear word address, byte count, `rx_err`, `overflow`.
  - LOAD: each `rx_valid` shifts the byte into lane `byte_cnt` (0..3) and increments `byte_cnt`. On the 4th byte, the next cycle writes the word, increments the address, and sets `byte_cnt` to 0.
  - LOAD → FLUSH when `load_imem` falls with `byte_cnt` ≠ 0. FLUSH writes the partial word with missing upper lanes = 0x00, then → IDLE.
  - LOAD → IDLE directly when `load_imem` falls with `byte_cnt` = 0.
- Simultaneous `rx_valid` and `load_imem` fall: the byte is accepted first, then flush/idle decision uses the updated `byte_cnt`.
- Word address wraps from 2^(ADDR_WIDTH-2)−1 to 0 and sets `overflow`. Writes continue.
- `reset` at any point:
  - Receiver → RX_IDLE, loader → IDLE.
  - The partial word is lost, with no write.
  - All outputs take their reset values.

## Timing
- Reset values:
  - `imem_wr`=0, `imem_addr`=0, `imem_wdata`=0.
  - `busy`=0, `rx_err`=0, `overflow`=0.
  - `cpu_hold` = `load_imem` (combinational OR with `busy`).
- Start-bit check occurs 2 + `BAUD_DIV/2` cycles after the pin falls. Data bit k is sampled `(k+1)·BAUD_DIV` cycles later.
- `rx_valid` is asserted the cycle after the stop-bit sample.
- `imem_wr` is asserted the cycle after the 4th `rx_valid`. `imem_addr` and `imem_wdata` are valid only while `imem_wr`=1.
- FLUSH write occurs one cycle after `load_imem` is sampled low. `busy` drops the cycle after that write.
- `load_imem` high-pulse shorter than one cycle is not supported. It is treated as a level sampled every cycle.

## Structure
- Shared package `uart_pkg`:
  - Receiver state enum.
  - Loader state enum (IDLE, LOAD, FLUSH).
  - Constant `UART_DATA_BITS` = 8.
- Sub-module `uart_rx_core` (synchronizer, bit counter, baud counter, `rx_valid`/`rx_byte`/`frame_err` outputs). It is reusable by a future SoC-side UART peripheral.
- Top contains the loader FSM, byte lane register, byte counter and word address counter.

## Test plan
All scenarios use `BAUD_DIV`=8.
- Send 0x13,0x00,0x00,0x00 with `load_imem`=1 → one `imem_wr`, addr 0, data 0x00000013; `busy`=1 throughout.
- Send 8 bytes 0x01..0x08 → writes addr 0 data 0x04030201, then addr 1 data 0x08070605.
- Send 0xAA,0xBB, then drop `load_imem` → FLUSH write addr 0 data 0x0000BBAA; `busy`=0 two cycles later.
- Send byte with stop bit 0, then 0x11,0x22,0x33,0x44 → `rx_err`=1, and a single write of 0x44332211 at addr 0.
- `ADDR_WIDTH`=4, send 5 words → 5th write at addr 0, `overflow`=1.
- Assert `reset` mid-byte after 2 accepted bytes, then re-raise `load_imem` and send 4 bytes → no write before reset; the new word is written at addr 0.
- Bytes sent with `load_imem`=0 → no `imem_wr`.
